// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit MIPS core front end.
// Holds the opcode map, the fetch sequencer state encoding and the instruction field slices.
package core_pkg;

   localparam logic [2:0] OP_RTYPE = 3'd0;
   localparam logic [2:0] OP_SLTI  = 3'd1;
   localparam logic [2:0] OP_J     = 3'd2;
   localparam logic [2:0] OP_JAL   = 3'd3;
   localparam logic [2:0] OP_LW    = 3'd4;
   localparam logic [2:0] OP_SW    = 3'd5;
   localparam logic [2:0] OP_BEQ   = 3'd6;
   localparam logic [2:0] OP_ADDI  = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam int OPC_HI  = 15;
   localparam int OPC_LO  = 13;
   localparam int JTGT_HI = 12;
   localparam int JTGT_LO = 0;
   localparam int BIMM_HI = 6;
   localparam int BIMM_LO = 0;

   function automatic logic [2:0] opc_of(input logic [15:0] word);
      return word[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/ifu_seq_if.sv
// Bus bundle between the fetch sequencer (master), instruction memory and decode/execute (slave).
// imem: imem_req is a one-cycle pulse; imem_rvalid/imem_rdata are taken only while a fetch is waiting.
// decode: instr/opcode/pc_p2 are stable while instr_valid=1; a transfer happens on instr_valid & instr_ready.
interface ifu_seq_if;
   import core_pkg::*;

   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;

   logic        instr_valid;
   logic [15:0] instr;
   logic [2:0]  opcode;
   logic [15:0] pc_p2;
   logic        instr_ready;

   logic        jump;
   logic        jr;
   logic [15:0] jr_target;
   logic        branch;
   logic        zero;

   logic        fetch_err;
   state_t      dbg_state;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, opcode, pc_p2, fetch_err, dbg_state,
      input  imem_rvalid, imem_rdata, instr_ready, jump, jr, jr_target, branch, zero
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, opcode, pc_p2, fetch_err, dbg_state,
      output imem_rvalid, imem_rdata, instr_ready, jump, jr, jr_target, branch, zero
   );

endinterface

// File: rtl/ifu_seq_pc_next.sv
// Combinational next-PC selection: JR, then J/JAL, then taken BEQ, else fall through.
module pc_next
   import core_pkg::*;
(
   input  logic [15:0] pc_p2,
   input  logic [12:0] jtgt,
   input  logic        jr,
   input  logic [15:0] jr_target,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic [15:0] next_pc
);

   logic [15:0] br_off;
   logic [15:0] br_pc;
   logic [15:0] j_pc;

   // Branch immediate is a signed halfword offset relative to pc+2.
   assign br_off = {{8{jtgt[BIMM_HI]}}, jtgt[BIMM_HI:BIMM_LO], 1'b0};
   assign br_pc  = pc_p2 + br_off;
   assign j_pc   = {pc_p2[15:14], jtgt[JTGT_HI:JTGT_LO], 1'b0};

   always_comb begin
      next_pc = pc_p2;
      if (jr) begin
         next_pc = jr_target & 16'hFFFE;
      end else if (jump) begin
         next_pc = j_pc;
      end else if (branch && zero) begin
         next_pc = br_pc;
      end
   end

endmodule

// File: rtl/ifu_seq.sv
// Instruction fetch and PC sequencer: fetches one word at a time, holds it for decode,
// and steps the PC from the jump/branch outcome when execute accepts the instruction.
module ifu_seq
   import core_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          TIMEOUT  = 15
)(
   input  logic      clk,
   input  logic      rst,
   ifu_seq_if.master bus
);

   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

   state_t      state, state_n;
   logic [15:0] pc, pc_n;
   logic [15:0] instr_r, instr_n;
   logic        vld, vld_n;
   logic        err, err_n;
   logic [7:0]  cnt, cnt_n;
   logic        req;
   logic [15:0] pc_p2;
   logic [15:0] next_pc;

   assign pc_p2 = pc + 16'd2;

   pc_next u_pc_next (
      .pc_p2     (pc_p2),
      .jtgt      (instr_r[JTGT_HI:JTGT_LO]),
      .jr        (bus.jr),
      .jr_target (bus.jr_target),
      .jump      (bus.jump),
      .branch    (bus.branch),
      .zero      (bus.zero),
      .next_pc   (next_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         instr_r <= 16'h0000;
         vld     <= 1'b0;
         err     <= 1'b0;
         cnt     <= 8'd0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         instr_r <= instr_n;
         vld     <= vld_n;
         err     <= err_n;
         cnt     <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = instr_r;
      vld_n   = vld;
      err_n   = err;
      cnt_n   = cnt;
      req     = 1'b0;
      case (state)
         IDLE: state_n = REQ;
         REQ: begin
            req     = 1'b1;
            cnt_n   = 8'd0;
            state_n = WAIT;
         end
         WAIT: begin
            // A response on the timeout cycle is still taken; no re-request then.
            if (bus.imem_rvalid) begin
               instr_n = bus.imem_rdata;
               vld_n   = 1'b1;
               state_n = HOLD;
            end else begin
               cnt_n = cnt + 8'd1;
               if (cnt_n == TO_CNT) begin
                  err_n   = 1'b1;
                  state_n = REQ;
               end
            end
         end
         HOLD: begin
            if (bus.instr_ready) begin
               pc_n    = next_pc;
               vld_n   = 1'b0;
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = vld;
   assign bus.instr       = instr_r;
   assign bus.opcode      = opc_of(instr_r);
   assign bus.pc_p2       = pc_p2;
   assign bus.fetch_err   = err;
   assign bus.dbg_state   = state;

endmodule

// File: tb/tb_ifu_seq.sv
// Self-checking bench for ifu_seq: directed scenarios plus randomized fetch traffic
// against an arithmetic next-PC model and a queue of expected fetch addresses.
module tb_ifu_seq;
   import core_pkg::*;

   localparam logic [15:0] RST_PC = 16'h0000;
   localparam int          TO     = 3;

   logic clk = 1'b0;
   logic rst;

   ifu_seq_if bus ();

   ifu_seq #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_q[$];
   logic        model_err;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] word,
                                               input logic j, input logic jrr, input logic [15:0] tgt,
                                               input logic br, input logic z);
      int seq, imm;
      seq = (int'(pc) + 2) % 65536;
      if (jrr) return 16'((int'(tgt) / 2) * 2);
      if (j) return 16'((seq / 16384) * 16384 + (int'(word) % 8192) * 2);
      if (br && z) begin
         imm = int'(word) % 128;
         if (imm >= 64) imm = imm - 128;
         return 16'((seq + 2 * imm + 65536) % 65536);
      end
      return 16'(seq);
   endfunction

   task automatic idle_inputs();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 16'h0000;
      bus.instr_ready = 1'b0;
      bus.jump        = 1'b0;
      bus.jr          = 1'b0;
      bus.jr_target   = 16'h0000;
      bus.branch      = 1'b0;
      bus.zero        = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.imem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL req_wait: imem_req=0 for 20 cycles, required 1");
      end
   endtask

   task automatic do_fetch(input logic [15:0] data, input int lat, input int hold,
                           input logic j, input logic jrr, input logic [15:0] tgt,
                           input logic br, input logic z);
      bit          ok;
      logic [15:0] pc, p2, nxt;
      wait_req(ok);
      if (!ok) return;
      pc = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hXXXX;
      p2 = 16'((int'(pc) + 2) % 65536);
      checks++;
      if (bus.imem_addr !== pc) begin
         errors++;
         $display("FAIL fetch_addr: got %h, required %h", bus.imem_addr, pc);
      end
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_outputs: req=%b valid=%b, required 0 0", bus.imem_req, bus.instr_valid);
      end
      repeat (lat) @(negedge clk);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = data;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 16'($urandom);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== data || bus.opcode !== data[15:13] ||
          bus.pc_p2 !== p2 || bus.fetch_err !== model_err) begin
         errors++;
         $display("FAIL hold_outputs: valid=%b instr=%h opc=%0d pc_p2=%h err=%b, required 1 %h %0d %h %b",
                  bus.instr_valid, bus.instr, bus.opcode, bus.pc_p2, bus.fetch_err,
                  data, data[15:13], p2, model_err);
      end
      for (int k = 0; k < hold; k++) begin
         bus.jump        = 1'($urandom);
         bus.jr          = 1'($urandom);
         bus.jr_target   = 16'($urandom);
         bus.branch      = 1'($urandom);
         bus.zero        = 1'($urandom);
         bus.imem_rvalid = 1'($urandom);
         @(negedge clk);
         checks++;
         if (bus.instr_valid !== 1'b1 || bus.instr !== data || bus.pc_p2 !== p2 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable: valid=%b instr=%h pc_p2=%h req=%b, required 1 %h %h 0",
                     bus.instr_valid, bus.instr, bus.pc_p2, bus.imem_req, data, p2);
         end
      end
      bus.imem_rvalid = 1'b0;
      bus.instr_ready = 1'b1;
      bus.jump        = j;
      bus.jr          = jrr;
      bus.jr_target   = tgt;
      bus.branch      = br;
      bus.zero        = z;
      nxt = model_next(pc, data, j, jrr, tgt, br, z);
      exp_q.push_back(nxt);
      @(negedge clk);
      idle_inputs();
      checks++;
      if (bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL accept_clear: instr_valid=%b, required 0", bus.instr_valid);
      end
   endtask

   task automatic plain(input logic [15:0] data);
      do_fetch(data, 0, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic steer(input logic [15:0] target);
      do_fetch(16'($urandom), 0, 0, 1'b0, 1'b1, target, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      model_err = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000 ||
          bus.fetch_err !== 1'b0 || bus.dbg_state !== IDLE || bus.imem_addr !== RST_PC) begin
         errors++;
         $display("FAIL reset_state: req=%b valid=%b instr=%h err=%b state=%0d addr=%h, required 0 0 0000 0 0 %h",
                  bus.imem_req, bus.instr_valid, bus.instr, bus.fetch_err, bus.dbg_state, bus.imem_addr, RST_PC);
      end
      exp_q.delete();
      exp_q.push_back(RST_PC);
      rst = 1'b0;
   endtask

   task automatic test_first_fetch();
      plain(16'hE005);
   endtask

   task automatic test_wrap();
      steer(16'hFFFC);
      plain(16'($urandom));
      plain(16'($urandom));
      plain(16'($urandom));
   endtask

   task automatic test_beq();
      steer(16'h0010);
      do_fetch(16'hC07E, 0, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      steer(16'h0010);
      do_fetch(16'hC07E, 1, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_jump();
      steer(16'h8000);
      do_fetch(16'h4123, 0, 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      steer(16'h8000);
      do_fetch(16'h6123, 2, 5, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_jr_priority();
      do_fetch(16'($urandom), 0, 0, 1'b1, 1'b1, 16'h1235, 1'b1, 1'b1);
      plain(16'($urandom));
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         do_fetch(16'($urandom), $urandom_range(0, TO - 1), $urandom_range(0, 3),
                  1'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom),
                  1'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_timeout();
      bit          ok;
      logic [15:0] pc;
      wait_req(ok);
      if (!ok) return;
      pc = (exp_q.size() > 0) ? exp_q[0] : 16'hXXXX;
      for (int c = 1; c <= TO; c++) begin
         @(negedge clk);
         checks++;
         if (bus.imem_req !== 1'b0 || bus.fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait: cycle %0d req=%b err=%b, required 0 0", c, bus.imem_req, bus.fetch_err);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc || bus.fetch_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_rereq: req=%b addr=%h err=%b, required 1 %h 1",
                  bus.imem_req, bus.imem_addr, bus.fetch_err, pc);
      end
      model_err = 1'b1;
      plain(16'($urandom));
      do_fetch(16'($urandom), TO - 1, 1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_fetch();
      bit ok;
      wait_req(ok);
      if (!ok) return;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.dbg_state !== IDLE || bus.instr_valid !== 1'b0 || bus.fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: state=%0d valid=%b err=%b, required 0 0 0",
                  bus.dbg_state, bus.instr_valid, bus.fetch_err);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 16'hE005;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
         errors++;
         $display("FAIL late_rvalid: valid=%b req=%b addr=%h, required 0 1 %h",
                  bus.instr_valid, bus.imem_req, bus.imem_addr, RST_PC);
      end
      bus.imem_rvalid = 1'b0;
      model_err = 1'b0;
      exp_q.delete();
      exp_q.push_back(RST_PC);
      plain(16'h2001);
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_wrap();
      test_beq();
      test_jump();
      test_jr_priority();
      test_random();
      test_timeout();
      test_reset_mid_fetch();
      plain(16'($urandom));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ifu_seq.md
Name: ifu_seq

Overview:
Instruction fetch and PC sequencer for the 16-bit MIPS core. It is the producing end of the opcode interface that drives the control decoder.
- Fetches one instruction at a time from instruction memory over a valid/ready-style request/response handshake.
- Presents the instruction, its 3-bit opcode and PC+2 to decode/execute.
- Computes the next PC from the decoder's jump/branch outcome and the ALU zero flag.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
TIMEOUT, 15, cycles to wait for an imem response before re-requesting (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  fetch request, one-cycle pulse
imem_addr  out  16  fetch address, equal to pc while in REQ/WAIT
imem_rvalid  in  1  response valid; sampled only in WAIT
imem_rdata  in  16  instruction word, valid with imem_rvalid
instr_valid  out  1  instruction held for decode
instr  out  16  held instruction word
opcode  out  3  instr[15:13], feeds control decoder
pc_p2  out  16  pc+2 of held instruction (JAL link value)
instr_ready  in  1  execute accepts held instruction this cycle
jump  in  1  decoder jump control (J/JAL)
jr  in  1  register jump (R-type JR, decoded downstream)
jr_target  in  16  register value for JR
branch  in  1  decoder branch control (BEQ)
zero  in  1  ALU zero flag for held instruction
fetch_err  out  1  sticky: at least one timeout occurred

Behaviour:
Reset (asynchronous, any state):
- pc=RESET_PC, state=IDLE.
- imem_req=0, instr_valid=0, instr=0, fetch_err=0, timeout counter=0.
- A fetch in flight is abandoned. A late imem_rvalid arriving in IDLE is ignored.

State machine:
- IDLE: one cycle after reset deassertion -> REQ.
- REQ: imem_req=1, imem_addr=pc, counter cleared -> WAIT.
- WAIT:
  - imem_rvalid=1: instr<=imem_rdata, instr_valid<=1 -> HOLD.
  - Otherwise counter increments; when counter==TIMEOUT, fetch_err<=1 -> REQ (same pc).
  - rvalid on the timeout cycle wins; no re-request.
- HOLD: instr_valid=1; instr, opcode and pc_p2 stable until acceptance.
  - instr_ready=1 (accept): pc<=next_pc, instr_valid<=0 -> REQ.
  - Control inputs are sampled only in the accept cycle.

pc_p2 = pc+16'd2, modulo 2^16 (0xFFFE+2 wraps to 0x0000).

next_pc priority, evaluated at accept:
1. jr=1: jr_target with bit0 forced to 0.
2. jump=1: {pc_p2[15:14], instr[12:0], 1'b0}.
3. branch=1 and zero=1: pc_p2 + (sext16(instr[6:0])<<1), modulo 2^16.
4. Otherwise: pc_p2.

Rules:
- branch=1 with zero=0 gives pc_p2.
- Simultaneous jr and jump: jr wins.
- Throughput: at most 1 instruction per 3 cycles with zero-latency memory (REQ, WAIT, HOLD).
- Exactly one imem request is outstanding at a time.
- imem_rvalid outside WAIT is ignored.

Decomposition:
Shared package core_pkg:
- opcode constants OP_RTYPE=0, OP_SLTI=1, OP_J=2, OP_JAL=3, OP_LW=4, OP_SW=5, OP_BEQ=6, OP_ADDI=7.
- state encoding IDLE/REQ/WAIT/HOLD.
- field slices: OPC=[15:13], JTGT=[12:0], BIMM=[6:0].

Sub-module: pc_next, a purely combinational next-PC mux/adder, instantiated once.

Test Plan:
1. Reset with RESET_PC=0, memory returns 16'h E005 (ADDI) after 1 cycle, instr_ready=1 -> imem_addr=0x0000, opcode=3'b111, pc_p2=0x0002; next request at 0x0002.
2. Sequential run from 0xFFFC with no controls -> fetches at 0xFFFC, 0xFFFE, 0x0000 (wrap).
3. BEQ 16'hC07E at pc=0x0010 (imm=-2):
   - branch=1, zero=1 -> next fetch 0x000E.
   - branch=1, zero=0 -> next fetch 0x0012.
4. J 16'h4123 at pc=0x8000 -> next fetch 0x8246. JAL at the same pc -> pc_p2=0x8002 held stable while instr_ready=0 for 5 cycles, then next fetch 0x8246.
5. jr=1, jump=1, jr_target=0x1235 -> next fetch 0x1234 (jr priority, bit0 cleared).
6. Timeouts and reset mid-fetch:
   - TIMEOUT=3, no rvalid -> imem_req re-pulses 4 cycles after the first, same addr, fetch_err=1.
   - rst asserted in WAIT, then rvalid arrives -> instr_valid stays 0 and the fetch restarts at RESET_PC.
